vrf_rd_stream: RTL and testbench

Read-side responder for the CGRA vector register file. It accepts per-element read requests from the vector auto-increment address generator, issues them to the VRF read port, and aligns the returned data through the fixed VRF read latency. The data is buffered and presented as a valid/ready stream to the stream-out / store path. It generates the `stall_rd` backpressure that the address generator uses as its clock enable, so no element is ever dropped or duplicated.

---
 rtl/vrf_stream_pkg.sv | 19 +
 rtl/vrf_rd_stream_if.sv | 30 +++
 rtl/vrf_rd_fifo.sv | 73 +++++++
 rtl/vrf_rd_stream.sv | 122 ++++++++++++
 tb/tb_vrf_rd_stream.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vrf_stream_pkg.sv
// Shared types and constants for the VRF read-side stream responder.
// Holds the read tag, latency bound and credit-counter width helper.
package vrf_stream_pkg;

    // Mirrors the VRF address width from the shared interface include.
    localparam int dwidth_RFadd = 8;

    localparam int RD_LAT_MAX = 4;

    typedef struct packed {
        logic valid;
        logic last;
    } vrf_tag_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vrf_rd_stream_if.sv
// Request, VRF read port and output stream bundle of vrf_rd_stream.
// slave: the responder; master: generator, VRF and sink side.
interface vrf_rd_stream_if
    import vrf_stream_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = dwidth_RFadd
);
    logic              req_valid;
    logic [AWIDTH-1:0] req_addr;
    logic              req_last;
    logic              stall_rd;
    logic              rf_ren;
    logic [AWIDTH-1:0] rf_raddr;
    logic [DWIDTH-1:0] rf_rdata;
    logic              m_tvalid;
    logic              m_tready;
    logic [DWIDTH-1:0] m_tdata;
    logic              m_tlast;

    modport slave (
        input  req_valid, req_addr, req_last, rf_rdata, m_tready,
        output stall_rd, rf_ren, rf_raddr, m_tvalid, m_tdata, m_tlast
    );

    modport master (
        output req_valid, req_addr, req_last, rf_rdata, m_tready,
        input  stall_rd, rf_ren, rf_raddr, m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/vrf_rd_fifo.sv
// Synchronous FIFO with registered count, full and empty flags.
// clr_i empties it in one cycle; storage itself is not reset.
module vrf_rd_fifo
    import vrf_stream_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [cnt_w(DEPTH)-1:0]  count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else if (clr_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_q + AW'(do_push);
            rd_q    <= rd_q + AW'(do_pop);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr_i) begin
            mem_q[wr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

// File: rtl/vrf_rd_stream.sv
// VRF read responder: credit-gated requests, latency-aligned capture, stream out.
// Define VRF_RD_STREAM_PERF_EN to add the saturating stall_cycles counter.
module vrf_rd_stream
    import vrf_stream_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = dwidth_RFadd,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    output logic            busy,
    vrf_rd_stream_if.slave  bus
`ifdef VRF_RD_STREAM_PERF_EN
    ,
    output logic [31:0]     stall_cycles
`endif
);
    localparam int CW = cnt_w(FIFO_DEPTH);
    localparam int FW = DWIDTH + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX ||
        FIFO_DEPTH < RD_LAT + 1 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("vrf_rd_stream: illegal RD_LAT/FIFO_DEPTH");
    end

    vrf_tag_t [RD_LAT-1:0] pipe_q, pipe_d;
    logic [CW-1:0]         fifo_cnt, inflight;
    logic [CW:0]           credit;
    logic [FW-1:0]         fifo_dout;
    logic [AWIDTH-1:0]     raddr;
    logic                  stall, accept, push, pop;
    logic                  fifo_full, fifo_empty;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (pipe_q[i].valid) inflight = inflight + CW'(1);
        end
    end

    // Credits use only registered state, so a pop pays back next cycle.
    assign credit = {1'b0, fifo_cnt} + {1'b0, inflight};
    assign stall  = flush | (credit >= DEPTH_C);
    assign accept = bus.req_valid & ~stall;
    assign raddr  = accept ? bus.req_addr : '0;

    assign bus.stall_rd = stall;
    assign bus.rf_ren   = accept;
    assign bus.rf_raddr = raddr;

    always_comb begin
        pipe_d = pipe_q;
        pipe_d[0].valid = accept;
        pipe_d[0].last  = accept & bus.req_last;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else if (flush) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign push = pipe_q[RD_LAT-1].valid;
    assign pop  = ~fifo_empty & bus.m_tready;

    vrf_rd_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush),
        .push_i  (push),
        .din_i   ({pipe_q[RD_LAT-1].last, bus.rf_rdata}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.m_tvalid = ~fifo_empty;
    assign {bus.m_tlast, bus.m_tdata} = fifo_empty ? '0 : fifo_dout;
    assign busy = (inflight != '0) | ~fifo_empty;

    overflow_a: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && fifo_full && !flush)
    );

`ifdef VRF_RD_STREAM_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (bus.req_valid && stall && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_vrf_rd_stream.sv
// Directed bench for vrf_rd_stream with a two-cycle VRF model.
// Scoreboard orders accepted requests against streamed beats.
module tb_vrf_rd_stream;
    import vrf_stream_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;
`ifdef VRF_RD_STREAM_PERF_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    vrf_rd_stream_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    vrf_rd_stream #(
        .DWIDTH     (DW),
        .AWIDTH     (AW),
        .RD_LAT     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
`ifdef VRF_RD_STREAM_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] vrf_word(input logic [7:0] a);
        return {8'hA5, 8'h3C, ~a, a};
    endfunction

    // VRF model: data for an address appears two cycles after rf_ren
    logic [31:0] vp1 = 32'hDEAD_BEEF;
    logic [31:0] vp2 = 32'hDEAD_BEEF;
    always @(posedge clk) begin
        vp1 <= bus.rf_ren ? vrf_word(bus.rf_raddr) : 32'hDEAD_BEEF;
        vp2 <= vp1;
    end
    assign bus.rf_rdata = vp2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [32:0] sb [$];
    logic [32:0] hold_val;
    logic [32:0] exp_beat;
    bit hold_pend = 0;
    int n_acc, n_beat, n_last, n_stall, first_acc, first_beat;
    bit drv_done;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 0;
        end else begin
            if (bus.stall_rd) n_stall++;
            if (bus.req_valid && !bus.stall_rd) begin
                check("rf_ren", bus.rf_ren, 1);
                check("rf_raddr", bus.rf_raddr, bus.req_addr);
                sb.push_back({bus.req_last, vrf_word(bus.req_addr)});
                if (n_acc == 0) first_acc = cyc;
                n_acc++;
            end
            if (hold_pend && bus.m_tvalid) begin
                check("hold", {bus.m_tlast, bus.m_tdata}, hold_val);
            end
            hold_pend = bus.m_tvalid && !bus.m_tready && !flush;
            hold_val  = {bus.m_tlast, bus.m_tdata};
            if (bus.m_tvalid && bus.m_tready) begin
                if (n_beat == 0) first_beat = cyc;
                n_beat++;
                if (bus.m_tlast) n_last++;
                if (sb.size() == 0) begin
                    check("spurious_beat", 1, 0);
                end else begin
                    exp_beat = sb.pop_front();
                    check("tdata", bus.m_tdata, exp_beat[31:0]);
                    check("tlast", bus.m_tlast, exp_beat[32]);
                end
            end
        end
    end

    task automatic clear_stats();
        n_acc = 0; n_beat = 0; n_last = 0; n_stall = 0;
        first_acc = 0; first_beat = 0;
    endtask

    task automatic send(input logic [7:0] a, input logic l);
        bit done = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_last  = l;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = !bus.stall_rd;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        bus.req_last  = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int max);
        bit ok = 0;
        for (int k = 0; k < max && !ok; k++) begin
            @(negedge clk);
            ok = !busy && !bus.m_tvalid && sb.size() == 0;
        end
        if (!ok) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drv(input int max);
        for (int k = 0; k < max && !drv_done; k++) @(posedge clk);
        if (!drv_done) check("drv_timeout", 0, 1);
        #1;
    endtask

    task automatic check_reset(input string t);
        check({t, "_stall"}, bus.stall_rd, 0);
        check({t, "_ren"}, bus.rf_ren, 0);
        check({t, "_raddr"}, bus.rf_raddr, 0);
        check({t, "_tvalid"}, bus.m_tvalid, 0);
        check({t, "_tdata"}, bus.m_tdata, 0);
        check({t, "_tlast"}, bus.m_tlast, 0);
        check({t, "_busy"}, busy, 0);
`ifdef VRF_RD_STREAM_PERF_EN
        check({t, "_stall_cycles"}, stall_cycles, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_last  = 1'b0;
        bus.m_tready  = 1'b0;
        clear_stats();

        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back vector
        clear_stats();
        bus.m_tready = 1'b1;
        for (int i = 0; i < 8; i++) send(8'(8'h10 + i), i == 7);
        wait_idle(50);
        check("b2b_beats", n_beat, 8);
        check("b2b_last", n_last, 1);
        check("b2b_latency", first_beat - first_acc, 3);
        check("b2b_stall", n_stall, 0);

        // backpressure
        clear_stats();
        bus.m_tready = 1'b0;
        drv_done = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) send(8'(8'h40 + i), i == 15);
                drv_done = 1;
            end
        join_none
        repeat (10) @(posedge clk);
        #1;
        check("bp_accepts", n_acc, 4);
        @(negedge clk);
        check("bp_stall_hi", bus.stall_rd, 1);
        @(posedge clk);
        #1;
        bus.m_tready = 1'b1;
        @(negedge clk);
        check("bp_stall_pop", bus.stall_rd, 1);
        @(negedge clk);
        check("bp_stall_drop", bus.stall_rd, 0);
        wait_drv(400);
        wait_idle(50);
        check("bp_beats", n_beat, 16);
        check("bp_last", n_last, 1);

        // random ready
        clear_stats();
        drv_done = 0;
        fork
            begin
                for (int i = 0; i < 64; i++) send(8'(i * 7 + 3), i == 63);
                drv_done = 1;
            end
        join_none
        for (int k = 0; k < 2000 && !drv_done; k++) begin
            @(posedge clk);
            #1;
            bus.m_tready = 1'($urandom_range(0, 1));
        end
        check("rnd_drv_done", drv_done, 1);
        bus.m_tready = 1'b1;
        wait_idle(100);
        check("rnd_beats", n_beat, 64);
        check("rnd_last", n_last, 1);

        // flush with 2 buffered and 2 in flight
        clear_stats();
        bus.m_tready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'h80 + i), i == 3);
        flush = 1'b1;
        sb.delete();
        @(negedge clk);
        check("fl_stall", bus.stall_rd, 1);
        check("fl_tvalid_pre", bus.m_tvalid, 1);
        check("fl_busy_pre", busy, 1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("fl_tvalid", bus.m_tvalid, 0);
        check("fl_busy", busy, 0);
        bus.m_tready = 1'b1;
        repeat (8) @(negedge clk);
        check("fl_beats", n_beat, 0);
        @(posedge clk);
        #1;

        // async reset mid-stream
        clear_stats();
        bus.m_tready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'(8'h20 + i), 1'b0);
        check("ar_tvalid_pre", bus.m_tvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("ar");
        sb.delete();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_stats();
        bus.m_tready = 1'b1;
        for (int i = 0; i < 4; i++) send(8'(8'h30 + i), i == 3);
        wait_idle(50);
        check("ar_beats", n_beat, 4);
        check("ar_last", n_last, 1);

        // sustained request against a blocked sink
        clear_stats();
        bus.m_tready  = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 8'h55;
        bus.req_last  = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("pf_accepts", n_acc, 4);
`ifdef VRF_RD_STREAM_PERF_EN
        check("pf_stall_cycles", stall_cycles, 10);
`endif
        bus.m_tready = 1'b1;
        wait_idle(50);
        check("pf_beats", n_beat, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
